// File: rtl/vedic_pkg.sv
// Shared types, default sizing and column-range helpers for the sequenced
// Urdhva-Tiryagbhyam multiplier.
//   state_t      : controller states
//   NDIG/NCOL/COLW: digit count, column count and column-index width at the
//                  default 64-bit operand / 8-bit digit configuration
//   col_first/col_last : first and last digit index i contributing to column k
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 64;
  localparam int DIGIT_DEF = 8;
  localparam int NDIG      = WIDTH_DEF / DIGIT_DEF;
  localparam int NCOL      = 2 * NDIG - 1;
  localparam int COLW      = $clog2(NCOL);

  // Column k collects every pair (i, j) with i + j = k and both inside 0..ndig-1.
  function automatic int col_first(input int k, input int ndig);
    return (k > ndig - 1) ? (k - ndig + 1) : 0;
  endfunction

  function automatic int col_last(input int k, input int ndig);
    return (k < ndig - 1) ? k : (ndig - 1);
  endfunction

endpackage

// File: rtl/vedic_digit_mult.sv
// Combinational DIGIT x DIGIT unsigned multiplier: the single shared
// partial-product resource scheduled by vedic_mult_sequencer. Kept as its own
// module so a vedic digit tree can be dropped in without touching the controller.
//   a_i, b_i : DIGIT-bit unsigned digits
//   p_o      : 2*DIGIT-bit product
module vedic_digit_mult #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0]   a_i,
  input  logic [DIGIT-1:0]   b_i,
  output logic [2*DIGIT-1:0] p_o
);

  assign p_o = {{DIGIT{1'b0}}, a_i} * {{DIGIT{1'b0}}, b_i};

endmodule

// File: rtl/vedic_mult_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier. One digit-pair product is
// formed per cycle, walking the Urdhva columns k = 0..2*NDIG-2 and, inside each
// column, i = col_first(k)..col_last(k) with j = k - i. Each partial product is
// shifted by DIGIT*k and added into a 2*WIDTH accumulator, which cannot overflow
// because the running sum never exceeds A*B.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B captured on acceptance)
//   out_valid/out_ready : result handshake, PRODUCT held while out_valid
//   busy                : high while running or holding a result
//   col_idx             : column being processed (0 when not running)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit-pair product accumulated per cycle, NDIG*NDIG cycles
// DONE  | PRODUCT presented with out_valid=1 until out_ready
module vedic_mult_sequencer
  import vedic_pkg::*;
#(
  parameter int WIDTH = 64,   // must be a multiple of DIGIT
  parameter int DIGIT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        A,
  input  logic [WIDTH-1:0]                        B,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2*WIDTH-1:0]                      PRODUCT,
  output logic                                    busy,
  output logic [$clog2(2*(WIDTH/DIGIT)-1)-1:0]    col_idx
);

  localparam int N_DIG = WIDTH / DIGIT;
  localparam int N_COL = 2 * N_DIG - 1;
  localparam int CW    = $clog2(N_COL);
  localparam int IW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        k_q, k_d;
  logic [IW-1:0]        i_q, i_d;
  logic                 in_ready_q, out_valid_q, busy_q;
  logic [DIGIT-1:0]     a_dig, b_dig;
  logic [2*DIGIT-1:0]   pp;
  logic                 col_end, last_pair;
  int                   j;

  vedic_digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  always_comb begin
    j         = int'(k_q) - int'(i_q);
    a_dig     = a_q[int'(i_q)*DIGIT +: DIGIT];
    b_dig     = b_q[j*DIGIT +: DIGIT];
    acc_d     = acc_q + ({{(2*WIDTH-2*DIGIT){1'b0}}, pp} << (DIGIT * int'(k_q)));
    col_end   = (int'(i_q) == col_last(int'(k_q), N_DIG));
    last_pair = col_end && (int'(k_q) == N_COL - 1);
    k_d       = k_q;
    i_d       = i_q + IW'(1);
    if (col_end) begin
      k_d = k_q + CW'(1);
      i_d = IW'(col_first(int'(k_q) + 1, N_DIG));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      i_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            acc_q      <= '0;
            k_q        <= '0;
            i_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_pair) begin
            // k returns to 0 so col_idx reads 0 outside RUN
            k_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_d;
            i_q <= i_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign PRODUCT   = acc_q;
  assign col_idx   = k_q;

endmodule

// File: tb/tb_vedic_mult_sequencer.sv
module tb_vedic_mult_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   A, B;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  PRODUCT;
  logic          busy;
  logic [3:0]    col_idx;

  int checks = 0;
  int errors = 0;

  int           col_trace [0:64];
  int           lat;
  logic [127:0] prod_obs;
  int           ir_bad;

  localparam int LAT_EXP = 64;  // RUN lasts NDIG*NDIG edges after the accept edge

  always #5 clk = ~clk;

  vedic_mult_sequencer #(.WIDTH(64), .DIGIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .PRODUCT   (PRODUCT),
    .busy      (busy),
    .col_idx   (col_idx)
  );

  // Stimulus: present one pair, then watch until out_valid (bounded).
  // Records latency, column trace, final product and handshake violations.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b);
    int n;
    int waitc;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = b ^ 64'hA5A5_5A5A_F00F_0FF0;
    n = 0;
    ir_bad = 0;
    for (int x = 0; x <= 64; x++) col_trace[x] = -1;
    while (out_valid !== 1'b1 && n < 200) begin
      if (n <= 64) col_trace[n] = int'(col_idx);
      if (in_ready !== 1'b0 || busy !== 1'b1) ir_bad++;
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (n <= 64) col_trace[n] = int'(col_idx);
    if (in_ready !== 1'b0 || busy !== 1'b1) ir_bad++;
    lat = (out_valid === 1'b1) ? n : -1;
    prod_obs = PRODUCT;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (PRODUCT !== 128'd0) begin errors++; $display("FAIL reset_product got %h want 0", PRODUCT); end
    checks++; if (col_idx !== 4'd0) begin errors++; $display("FAIL reset_col_idx got %0d want 0", col_idx); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    run_op(64'd3, 64'd5);
    checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT_EXP); end
    checks++; if (prod_obs !== 128'd15) begin errors++; $display("FAIL basic_product got %h want %h", prod_obs, 128'd15); end
    checks++; if (ir_bad !== 0) begin errors++; $display("FAIL basic_in_ready_busy got %0d bad cycles want 0", ir_bad); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero();
    run_op(64'd0, 64'h1234_5678_9ABC_DEF0);
    checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, LAT_EXP); end
    checks++; if (prod_obs !== 128'd0) begin errors++; $display("FAIL zero_product got %h want 0", prod_obs); end
    drain();
  endtask

  task automatic test_max();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL max_latency got %0d want %0d", lat, LAT_EXP); end
    checks++;
    if (prod_obs !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++; $display("FAIL max_product got %h want %h", prod_obs, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    end
    drain();
  endtask

  task automatic test_pattern();
    logic [63:0]  a, b;
    logic [127:0] ref_p;
    int           exp_col [0:64];
    int           idx;
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    ref_p = {64'd0, a} * {64'd0, b};
    idx = 0;
    for (int k = 0; k < 15; k++) begin
      for (int d = 0; d < ((k < 8) ? k + 1 : 15 - k); d++) begin
        exp_col[idx] = k;
        idx++;
      end
    end
    exp_col[64] = 0;
    run_op(a, b);
    checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL pattern_latency got %0d want %0d", lat, LAT_EXP); end
    checks++; if (prod_obs !== ref_p) begin errors++; $display("FAIL pattern_product got %h want %h", prod_obs, ref_p); end
    for (int n = 0; n <= 64; n++) begin
      checks++;
      if (col_trace[n] !== exp_col[n]) begin
        errors++; $display("FAIL pattern_col_idx cycle %0d got %0d want %0d", n, col_trace[n], exp_col[n]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    // (2^32+1) * (2^32-1) = 2^64-1
    run_op(64'h0000_0001_0000_0001, 64'h0000_0000_FFFF_FFFF);
    checks++;
    if (prod_obs !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL bp_product got %h want %h", prod_obs, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      A = 64'd100 + 64'(c);
      B = 64'd200 + 64'(c);
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", c, out_valid); end
      checks++;
      if (PRODUCT !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin
        errors++; $display("FAIL bp_product_hold cycle %0d got %h want %h", c, PRODUCT, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_ghost_start got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    A = 64'hDEAD_BEEF_0000_1111; B = 64'h1234_0000_5555_7777; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (PRODUCT !== 128'd0) begin errors++; $display("FAIL midrst_product got %h want 0", PRODUCT); end
    checks++; if (col_idx !== 4'd0) begin errors++; $display("FAIL midrst_col_idx got %0d want 0", col_idx); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    run_op(64'd7, 64'd9);
    checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL midrst_after_latency got %0d want %0d", lat, LAT_EXP); end
    checks++; if (prod_obs !== 128'd63) begin errors++; $display("FAIL midrst_after_product got %h want %h", prod_obs, 128'd63); end
    drain();
  endtask

  task automatic test_back_to_back();
    localparam int N = 400;
    logic [127:0] q [$];
    int recv;
    int dup;
    recv = 0;
    dup  = 0;
    fork
      begin : drv
        for (int p = 0; p < N; p++) begin
          logic [63:0] a, b;
          logic        ok;
          int          tries;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          if (p % 37 == 0) a = 64'd0;
          if (p % 41 == 0) b = 64'hFFFF_FFFF_FFFF_FFFF;
          A = a; B = b; in_valid = 1'b1;
          tries = 0;
          ok = 1'b0;
          while (!ok && tries < 500) begin
            ok = (in_ready === 1'b1);
            @(posedge clk); @(negedge clk);
            tries++;
          end
          in_valid = 1'b0;
          if (ok) q.push_back({64'd0, a} * {64'd0, b});
        end
      end
      begin : mon
        int cyc;
        logic [127:0] want;
        cyc = 0;
        while (recv < N && cyc < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
              dup++;
            end else begin
              want = q.pop_front();
              checks++;
              if (PRODUCT !== want) begin
                errors++; $display("FAIL b2b_product #%0d got %h want %h", recv, PRODUCT, want);
              end
              recv++;
            end
          end
          @(posedge clk); @(negedge clk);
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++; if (recv !== N) begin errors++; $display("FAIL b2b_count got %0d want %0d", recv, N); end
    checks++; if (dup !== 0) begin errors++; $display("FAIL b2b_duplicates got %0d want 0", dup); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_pattern();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
